// File: rtl/hdb3_rx_ctrl.sv
// hdb3_rx_ctrl: receive-side sequencer for the HDB3 decoder path.
// Divides clk down to the symbol rate and forwards one symbol per strobe to
// the decoder. Discards decoder warm-up bits and packs decoded bits into
// bytes behind a valid/ready handshake. Flags code errors, LOS and overflow.
module hdb3_rx_ctrl #(
  parameter int unsigned CLK_DIV   = 16,
  parameter int unsigned LOS_LIMIT = 32,
  parameter int unsigned DEC_LAT   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [1:0] line_in,
  output logic [1:0] hdb3_out,
  output logic       dec_valid,
  input  logic       dec_bit,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  input  logic       byte_ready,
  output logic       los,
  output logic       code_err,
  output logic       overflow,
  input  logic       clr_status
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned ZR_W  = $clog2(LOS_LIMIT + 1);
  localparam int unsigned WU_W  = (DEC_LAT > 1) ? $clog2(DEC_LAT) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WARM = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_LOS  = 2'd3;

  localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(CLK_DIV - 1);
  localparam logic [ZR_W-1:0]  ZR_LIMIT = ZR_W'(LOS_LIMIT);
  localparam logic [ZR_W-1:0]  ZR_ERR   = ZR_W'(3);
  localparam logic [WU_W-1:0]  WU_LAST  = WU_W'(DEC_LAT - 1);

  logic [1:0]       state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [ZR_W-1:0]  zrun_q, zrun_d;
  logic [WU_W-1:0]  warm_q, warm_d;
  logic [2:0]       bitcnt_q, bitcnt_d;
  logic [6:0]       shift_q, shift_d;
  logic             samp_q, samp_d;
  logic [1:0]       hdb3_q, hdb3_d;
  logic             dv_q, dv_d;
  logic             ce_q, ce_d;
  logic             los_q, los_d;
  logic [7:0]       bd_q, bd_d;
  logic             bv_q, bv_d;
  logic             ov_q, ov_d;

  logic strobe_c;
  logic sample_c;
  logic sym_zero_c;
  logic byte_load;
  logic byte_drop;

  // Symbol strobe, decoder-bit sample point and zero-symbol classification
  assign strobe_c   = enable && (state_q != S_IDLE) && (div_q == DIV_MAX);
  assign sample_c   = enable && samp_q;
  assign sym_zero_c = (line_in == 2'b00) || (line_in == 2'b11);

  // Next-state and registered-output logic
  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    zrun_d    = zrun_q;
    warm_d    = warm_q;
    bitcnt_d  = bitcnt_q;
    shift_d   = shift_q;
    samp_d    = 1'b0;
    hdb3_d    = hdb3_q;
    dv_d      = 1'b0;
    ce_d      = 1'b0;
    bd_d      = bd_q;
    bv_d      = bv_q;
    ov_d      = ov_q;
    byte_load = 1'b0;
    byte_drop = 1'b0;

    if (!enable) begin
      state_d  = S_IDLE;
      div_d    = '0;
      zrun_d   = '0;
      warm_d   = '0;
      bitcnt_d = '0;
      shift_d  = '0;
    end else begin
      div_d  = ((state_q == S_IDLE) || (div_q == DIV_MAX)) ? '0 : div_q + DIV_W'(1);
      samp_d = dv_q;

      if (strobe_c) begin
        hdb3_d = (line_in == 2'b11) ? 2'b00 : line_in;
        dv_d   = 1'b1;
      end

      case (state_q)
        S_IDLE: begin
          state_d = S_WARM;
          zrun_d  = '0;
          warm_d  = '0;
        end
        S_WARM, S_RUN: begin
          if (strobe_c) begin
            if (state_q == S_RUN) begin
              ce_d = (line_in == 2'b11) || (sym_zero_c && (zrun_q >= ZR_ERR));
            end
            if (sym_zero_c) begin
              zrun_d = zrun_q + ZR_W'(1);
              if (zrun_d == ZR_LIMIT) begin
                state_d  = S_LOS;
                bitcnt_d = '0;
                shift_d  = '0;
              end
            end else begin
              zrun_d = '0;
            end
          end
          if (sample_c) begin
            if (state_q == S_WARM) begin
              if (warm_q == WU_LAST) begin
                state_d = S_RUN;
              end else begin
                warm_d = warm_q + WU_W'(1);
              end
            end else begin
              shift_d  = {dec_bit, shift_q[6:1]};
              bitcnt_d = bitcnt_q + 3'd1;
              if (bitcnt_q == 3'd7) begin
                shift_d = '0;
                if (!bv_q || byte_ready) begin
                  byte_load = 1'b1;
                end else begin
                  byte_drop = 1'b1;
                end
              end
            end
          end
        end
        S_LOS: begin
          if (strobe_c && !sym_zero_c) begin
            state_d = S_WARM;
            warm_d  = '0;
            zrun_d  = '0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    // Output byte register: a new byte wins over the handshake release
    if (byte_load) begin
      bd_d = {dec_bit, shift_q};
      bv_d = 1'b1;
    end else if (bv_q && byte_ready) begin
      bv_d = 1'b0;
    end

    // Sticky overflow: a drop in the same cycle beats a clear
    if (byte_drop) begin
      ov_d = 1'b1;
    end else if (clr_status) begin
      ov_d = 1'b0;
    end

    los_d = (state_d == S_LOS);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      div_q    <= '0;
      zrun_q   <= '0;
      warm_q   <= '0;
      bitcnt_q <= '0;
      shift_q  <= '0;
      samp_q   <= 1'b0;
      hdb3_q   <= 2'b00;
      dv_q     <= 1'b0;
      ce_q     <= 1'b0;
      los_q    <= 1'b0;
      bd_q     <= '0;
      bv_q     <= 1'b0;
      ov_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      zrun_q   <= zrun_d;
      warm_q   <= warm_d;
      bitcnt_q <= bitcnt_d;
      shift_q  <= shift_d;
      samp_q   <= samp_d;
      hdb3_q   <= hdb3_d;
      dv_q     <= dv_d;
      ce_q     <= ce_d;
      los_q    <= los_d;
      bd_q     <= bd_d;
      bv_q     <= bv_d;
      ov_q     <= ov_d;
    end
  end

  assign hdb3_out   = hdb3_q;
  assign dec_valid  = dv_q;
  assign code_err   = ce_q;
  assign los        = los_q;
  assign byte_data  = bd_q;
  assign byte_valid = bv_q;
  assign overflow   = ov_q;

endmodule

// File: tb/tb_hdb3_rx_ctrl.sv
// tb_hdb3_rx_ctrl: directed bench for hdb3_rx_ctrl with a behavioural model
// compared every cycle plus hand-computed literal expectations.
module tb_hdb3_rx_ctrl;

  localparam int CLK_DIV   = 4;
  localparam int LOS_LIMIT = 8;
  localparam int DEC_LAT   = 4;

  localparam int M_IDLE = 0;
  localparam int M_WARM = 1;
  localparam int M_RUN  = 2;
  localparam int M_LOS  = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic [1:0] line_in;
  logic [1:0] hdb3_out;
  logic       dec_valid;
  logic       dec_bit;
  logic [7:0] byte_data;
  logic       byte_valid;
  logic       byte_ready;
  logic       los;
  logic       code_err;
  logic       overflow;
  logic       clr_status;

  int n_chk = 0;
  int n_pass = 0;
  logic chk_en = 1'b0;
  logic pol = 1'b0;
  logic [7:0] pat;

  // monitor captures
  int cyc = 0;
  int en_cyc = 0;
  int dv_n = 0;
  int dv_cyc0 = 0;
  int dv_cyc1 = 0;
  logic [1:0] dv_hdb0 = 2'b00;
  logic [1:0] dv_hdb1 = 2'b00;
  int bv_cnt = 0;
  int ce_cnt = 0;
  logic [7:0] last_byte = 8'h00;
  logic [1:0] ce_hdb = 2'b11;

  // model state
  int m_mode, ph, sd, zr, warm_left;
  bit bits[$];
  logic [1:0] e_hdb;
  logic e_dv, e_ce, e_los, e_bv, e_ov;
  logic [7:0] e_bd, nb;
  logic load, drop, acc, z;

  hdb3_rx_ctrl #(.CLK_DIV(CLK_DIV), .LOS_LIMIT(LOS_LIMIT), .DEC_LAT(DEC_LAT)) dut (
    .clk(clk), .rst(rst), .enable(enable), .line_in(line_in),
    .hdb3_out(hdb3_out), .dec_valid(dec_valid), .dec_bit(dec_bit),
    .byte_data(byte_data), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .los(los), .code_err(code_err), .overflow(overflow), .clr_status(clr_status)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: symbol-level rules, evaluated once per clock
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_mode = M_IDLE; ph = 0; sd = 0; zr = 0; warm_left = 0; bits.delete();
      e_hdb = 2'b00; e_dv = 1'b0; e_ce = 1'b0; e_los = 1'b0;
      e_bv = 1'b0; e_bd = 8'h00; e_ov = 1'b0;
    end else begin
      acc = e_bv && byte_ready; load = 1'b0; drop = 1'b0; nb = 8'h00;
      e_dv = 1'b0; e_ce = 1'b0;
      if (!enable) begin
        m_mode = M_IDLE; ph = 0; sd = 0; zr = 0; bits.delete();
      end else if (m_mode == M_IDLE) begin
        m_mode = M_WARM; ph = 0; warm_left = DEC_LAT; zr = 0;
      end else begin
        if (sd > 0) begin
          sd = sd - 1;
          if (sd == 0) begin
            if (m_mode == M_RUN) begin
              bits.push_back(dec_bit);
              if (bits.size() == 8) begin
                for (int i = 0; i < 8; i++) if (bits[i]) nb = nb | (8'd1 << i);
                bits.delete();
                if (!e_bv || byte_ready) load = 1'b1; else drop = 1'b1;
              end
            end else if (m_mode == M_WARM) begin
              warm_left = warm_left - 1;
              if (warm_left == 0) m_mode = M_RUN;
            end
          end
        end
        if (ph == CLK_DIV - 1) begin
          e_dv = 1'b1;
          e_hdb = (line_in == 2'b11) ? 2'b00 : line_in;
          z = (line_in == 2'b00) || (line_in == 2'b11);
          if (m_mode == M_RUN) e_ce = (line_in == 2'b11) || (z && zr >= 3);
          if (m_mode == M_WARM || m_mode == M_RUN) begin
            zr = z ? zr + 1 : 0;
            if (zr == LOS_LIMIT) begin m_mode = M_LOS; bits.delete(); end
          end else if (m_mode == M_LOS && !z) begin
            m_mode = M_WARM; warm_left = DEC_LAT; zr = 0;
          end
          sd = 2;
        end
        ph = (ph + 1) % CLK_DIV;
      end
      if (load) begin e_bv = 1'b1; e_bd = nb; end
      else if (acc) e_bv = 1'b0;
      if (drop) e_ov = 1'b1;
      else if (clr_status) e_ov = 1'b0;
      e_los = (m_mode == M_LOS);
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("hdb3_out", 8'(hdb3_out), 8'(e_hdb));
      chk("dec_valid", 8'(dec_valid), 8'(e_dv));
      chk("code_err", 8'(code_err), 8'(e_ce));
      chk("los", 8'(los), 8'(e_los));
      chk("byte_valid", 8'(byte_valid), 8'(e_bv));
      chk("overflow", 8'(overflow), 8'(e_ov));
      if (e_bv) chk("byte_data", byte_data, e_bd);
    end
  end

  // Event capture for the literal expectations
  always @(negedge clk) begin
    if (dec_valid && dv_n == 0) begin dv_cyc0 = cyc; dv_hdb0 = hdb3_out; dv_n++; end
    else if (dec_valid && dv_n == 1) begin dv_cyc1 = cyc; dv_hdb1 = hdb3_out; dv_n++; end
    if (byte_valid) begin bv_cnt++; last_byte = byte_data; end
    if (code_err) begin ce_cnt++; ce_hdb = hdb3_out; end
  end

  task automatic sym(input logic [1:0] s, input logic b);
    line_in = s;
    dec_bit = b;
    repeat (CLK_DIV) @(negedge clk);
  endtask

  task automatic mark(input logic b);
    pol = ~pol;
    sym(pol ? 2'b01 : 2'b10, b);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_hdb3_out"}, 8'(hdb3_out), 8'h00);
    chk({tag, "_dec_valid"}, 8'(dec_valid), 8'h00);
    chk({tag, "_byte_data"}, byte_data, 8'h00);
    chk({tag, "_byte_valid"}, 8'(byte_valid), 8'h00);
    chk({tag, "_los"}, 8'(los), 8'h00);
    chk({tag, "_code_err"}, 8'(code_err), 8'h00);
    chk({tag, "_overflow"}, 8'(overflow), 8'h00);
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; line_in = 2'b00; dec_bit = 1'b0;
    byte_ready = 1'b1; clr_status = 1'b0;
    #2 rst = 1'b0;
    #1 chk_all_zero("reset");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    chk_en = 1'b1;

    // 1: start-up timing and symbol forwarding
    @(negedge clk);
    enable = 1'b1;
    en_cyc = cyc + 1;
    @(negedge clk);
    repeat (5) mark(1'b0);
    #1;
    chk("first_dv_latency", 8'(dv_cyc0 - en_cyc), 8'd4);
    chk("dv_period", 8'(dv_cyc1 - dv_cyc0), 8'd4);
    chk("first_hdb3", 8'(dv_hdb0), 8'h01);
    chk("second_hdb3", 8'(dv_hdb1), 8'h02);

    // 2: first RUN byte 1,0,1,1,0,0,1,0 -> 8'h4D
    bv_cnt = 0;
    pat = 8'h4D;
    for (int i = 0; i < 8; i++) begin mark(pat[0]); pat = pat >> 1; end
    #1;
    chk("byte1_valid_cycles", 8'(bv_cnt), 8'd1);
    chk("byte1_data", last_byte, 8'h4D);

    // 3: illegal symbol, then four zeros
    ce_cnt = 0;
    sym(2'b11, 1'b1);
    mark(1'b1);
    #1;
    chk("illegal_pulses", 8'(ce_cnt), 8'd1);
    chk("illegal_hdb3", 8'(ce_hdb), 8'h00);
    ce_cnt = 0;
    repeat (4) sym(2'b00, 1'b1);
    mark(1'b1);
    #1;
    chk("zero4_pulses", 8'(ce_cnt), 8'd1);

    // 4: LOS after LOS_LIMIT zeros, recovery with partial byte dropped
    repeat (8) sym(2'b00, 1'b1);
    #1 chk("los_set", 8'(los), 8'd1);
    mark(1'b0);
    #1 chk("los_clear", 8'(los), 8'd0);
    repeat (4) mark(1'b0);
    bv_cnt = 0;
    pat = 8'h96;
    for (int i = 0; i < 8; i++) begin mark(pat[0]); pat = pat >> 1; end
    #1;
    chk("recover_byte_cnt", 8'(bv_cnt), 8'd1);
    chk("recover_byte", last_byte, 8'h96);

    // 5: back-pressure overflow, clear, async reset mid-byte
    byte_ready = 1'b0;
    pat = 8'h03;
    for (int i = 0; i < 8; i++) begin mark(pat[0]); pat = pat >> 1; end
    repeat (8) mark(1'b1);
    #1;
    chk("held_valid", 8'(byte_valid), 8'd1);
    chk("held_data", byte_data, 8'h03);
    chk("overflow_set", 8'(overflow), 8'd1);
    clr_status = 1'b1;
    @(negedge clk);
    clr_status = 1'b0;
    #1 chk("overflow_clr", 8'(overflow), 8'd0);
    repeat (3) mark(1'b1);
    #2 rst = 1'b0;
    #1 chk_all_zero("midreset");
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
